// File: rtl/iob_cache_write_buffer.sv
// -----------------------------------------------------------------------------
// iob_cache_write_buffer
//
// Write-through buffer between the cache front-end and the back-end write
// channel. Front-end word writes {addr, wdata, wstrb} are queued in a small
// circular FIFO. They drain one at a time, in strict order, over the
// write_valid/write_ready handshake. The front-end can therefore retire writes
// without waiting on back-end memory latency.
//
// Optional feature macro: IOB_CACHE_WTB_MERGE_EN
//   When defined, a push whose word address matches the newest entry merges
//   into that entry. The newest entry must not be the head that is under
//   handshake, so level must be >= 2. When undefined, every accepted push
//   allocates a new entry.
//
// Ports
//   clk_i        in   clock, single domain
//   reset        in   synchronous active-low reset
//   push         in   front-end write request (single-cycle qualifier)
//   push_addr    in   word address
//   push_wdata   in   write data
//   push_wstrb   in   byte enables (nonzero)
//   full         out  no free entry (from registered level)
//   empty        out  no entry held (from registered level)
//   level        out  number of entries held, 0..DEPTH
//   write_valid  out  head entry presented to the write channel
//   write_addr   out  head address
//   write_wdata  out  head data
//   write_wstrb  out  head strobe
//   write_ready  in   write channel completed the head transfer
//
// Handshake: a transfer happens on a rising edge where write_valid and
// write_ready are both 1. While write_valid=1 and write_ready=0, the head
// fields are held stable. write_ready is ignored while write_valid=0. There
// is no ready on the push side; upstream must gate push on full.
// -----------------------------------------------------------------------------
module iob_cache_write_buffer #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int DEPTH_W = 2
) (
   input  logic                                   clk_i,
   input  logic                                   reset,
   input  logic                                   push,
   input  logic [ADDR_W-$clog2(DATA_W/8)-1:0]     push_addr,
   input  logic [DATA_W-1:0]                      push_wdata,
   input  logic [DATA_W/8-1:0]                    push_wstrb,
   output logic                                   full,
   output logic                                   empty,
   output logic [DEPTH_W:0]                       level,
   output logic                                   write_valid,
   output logic [ADDR_W-$clog2(DATA_W/8)-1:0]     write_addr,
   output logic [DATA_W-1:0]                      write_wdata,
   output logic [DATA_W/8-1:0]                    write_wstrb,
   input  logic                                   write_ready
);

   localparam int NBYTES   = DATA_W / 8;
   localparam int NBYTES_W = $clog2(NBYTES);
   localparam int AW       = ADDR_W - NBYTES_W;
   localparam int DEPTH    = 1 << DEPTH_W;

   logic [AW-1:0]     addr_q  [DEPTH];
   logic [DATA_W-1:0] wdata_q [DEPTH];
   logic [NBYTES-1:0] wstrb_q [DEPTH];
   logic [DEPTH_W-1:0] rptr_q, wptr_q;
   logic [DEPTH_W:0]   level_q, level_d;

   logic pop;
   logic merge;
   logic alloc;

   // level never exceeds DEPTH, so its MSB alone marks the full state
   assign empty       = (level_q == '0);
   assign full        = level_q[DEPTH_W];
   assign level       = level_q;
   assign write_valid = !empty;
   assign write_addr  = addr_q[rptr_q];
   assign write_wdata = wdata_q[rptr_q];
   assign write_wstrb = wstrb_q[rptr_q];

   assign pop = write_valid && write_ready;

`ifdef IOB_CACHE_WTB_MERGE_EN
   logic [DEPTH_W-1:0] newest;
   assign newest = wptr_q - 1'b1;
   // level >= 2 keeps the merge target away from the head under handshake.
   // A merge is allowed even when full, because it needs no new slot.
   assign merge  = push && (level_q > (DEPTH_W+1)'(1))
                   && !(pop && (rptr_q == newest))
                   && (push_addr == addr_q[newest]);
`else
   assign merge  = 1'b0;
`endif

   assign alloc = push && !full && !merge;

   always_comb begin
      level_d = level_q;
      if (alloc && !pop) begin
         level_d = level_q + 1'b1;
      end else if (!alloc && pop) begin
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         level_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i]  <= '0;
            wdata_q[i] <= '0;
            wstrb_q[i] <= '0;
         end
      end else begin
         if (alloc) begin
            addr_q[wptr_q]  <= push_addr;
            wdata_q[wptr_q] <= push_wdata;
            wstrb_q[wptr_q] <= push_wstrb;
            wptr_q          <= wptr_q + 1'b1;
         end
`ifdef IOB_CACHE_WTB_MERGE_EN
         if (merge) begin
            for (int b = 0; b < NBYTES; b++) begin
               if (push_wstrb[b]) begin
                  wdata_q[newest][b*8 +: 8] <= push_wdata[b*8 +: 8];
               end
            end
            wstrb_q[newest] <= wstrb_q[newest] | push_wstrb;
         end
`endif
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
         level_q <= level_d;
      end
   end

endmodule

// File: tb/tb_iob_cache_write_buffer.sv
// Directed bench for iob_cache_write_buffer (ADDR_W=32, DATA_W=32, DEPTH_W=2).
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_iob_cache_write_buffer;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int DEPTH_W = 2;
   localparam int NB      = DATA_W / 8;
   localparam int AW      = ADDR_W - $clog2(NB);

   // clock / reset
   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic              reset;
   logic              push;
   logic [AW-1:0]     push_addr;
   logic [DATA_W-1:0] push_wdata;
   logic [NB-1:0]     push_wstrb;
   logic              full, empty;
   logic [DEPTH_W:0]  level;
   logic              write_valid;
   logic [AW-1:0]     write_addr;
   logic [DATA_W-1:0] write_wdata;
   logic [NB-1:0]     write_wstrb;
   logic              write_ready;

   iob_cache_write_buffer #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH_W(DEPTH_W)
   ) dut (
      .clk_i      (clk_i),
      .reset      (reset),
      .push       (push),
      .push_addr  (push_addr),
      .push_wdata (push_wdata),
      .push_wstrb (push_wstrb),
      .full       (full),
      .empty      (empty),
      .level      (level),
      .write_valid(write_valid),
      .write_addr (write_addr),
      .write_wdata(write_wdata),
      .write_wstrb(write_wstrb),
      .write_ready(write_ready)
   );

   // scoreboard
   int checks = 0;
   int errors = 0;
   logic [AW-1:0]     exp_q[$];
   logic [DATA_W-1:0] expd_q[$];
   logic [NB-1:0]     exps_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   // drive one push for the coming edge; queue it in the model if it allocates
   task automatic drive_push(input logic [AW-1:0] a, input logic [DATA_W-1:0] d,
                             input logic [NB-1:0] s, input bit allocates);
      push       = 1'b1;
      push_addr  = a;
      push_wdata = d;
      push_wstrb = s;
      if (allocates) begin
         exp_q.push_back(a);
         expd_q.push_back(d);
         exps_q.push_back(s);
      end
   endtask

   // call before an edge where write_ready=1 and write_valid=1
   task automatic check_head();
      if (exp_q.size() == 0) begin
         check("head_unexpected", 64'(write_valid), 64'd0);
      end else begin
         check("head_addr",  64'(write_addr),  64'(exp_q.pop_front()));
         check("head_wdata", 64'(write_wdata), 64'(expd_q.pop_front()));
         check("head_wstrb", 64'(write_wstrb), 64'(exps_q.pop_front()));
      end
   endtask

   task automatic drain();
      push        = 1'b0;
      write_ready = 1'b1;
      for (int k = 0; k < 16 && write_valid; k++) begin
         check_head();
         tick();
      end
      write_ready = 1'b0;
      check("drain_empty", 64'(empty), 64'd1);
      check("drain_qsize", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_empty"}, 64'(empty), 64'd1);
      check({tag, "_full"},  64'(full),  64'd0);
      check({tag, "_level"}, 64'(level), 64'd0);
      check({tag, "_valid"}, 64'(write_valid), 64'd0);
      check({tag, "_addr"},  64'(write_addr),  64'd0);
      check({tag, "_wdata"}, 64'(write_wdata), 64'd0);
      check({tag, "_wstrb"}, 64'(write_wstrb), 64'd0);
   endtask

   initial begin
      reset = 1'b0; push = 1'b0; push_addr = '0; push_wdata = '0; push_wstrb = '0;
      write_ready = 1'b0;
      tick(); tick();
      reset = 1'b1;
      check_reset_state("rst");

      // 1: single push, held while not ready, then popped
      drive_push(AW'('h10), 32'hAABBCCDD, 4'hF, 1'b1);
      tick();
      push = 1'b0;
      check("t1_valid", 64'(write_valid), 64'd1);
      check("t1_level", 64'(level), 64'd1);
      for (int i = 0; i < 5; i++) begin
         check("t1_hold_addr",  64'(write_addr),  64'h10);
         check("t1_hold_wdata", 64'(write_wdata), 64'hAABBCCDD);
         tick();
      end
      write_ready = 1'b1;
      check_head();
      tick();
      write_ready = 1'b0;
      check("t1_empty", 64'(empty), 64'd1);

      // 2: fill to full, overflow push ignored, drain in order
      for (int i = 1; i <= 4; i++) begin
         drive_push(AW'(i), 32'h1000 + 32'(i), 4'hF, 1'b1);
         tick();
      end
      push = 1'b0;
      check("t2_full",  64'(full),  64'd1);
      check("t2_level", 64'(level), 64'd4);
      drive_push(AW'(5), 32'h5555, 4'hF, 1'b0);
      tick();
      push = 1'b0;
      check("t2_ovf_level", 64'(level), 64'd4);
      check("t2_ovf_head",  64'(write_addr), 64'd1);
      drain();

      // 3: streaming, one push and one pop per cycle
      for (int i = 0; i < 20; i++) begin
         drive_push(AW'(i), 32'(i) * 32'd3, 4'hF, 1'b1);
         write_ready = 1'b1;
         if (write_valid) check_head();
         if (i > 0) check("t3_level", 64'(level), 64'd1);
         tick();
      end
      drain();

      // 4: reset mid-transfer discards everything
      for (int i = 0; i < 3; i++) begin
         drive_push(AW'('h100 + i), 32'hC0DE0000 + 32'(i), 4'hF, 1'b1);
         tick();
      end
      push = 1'b0;
      check("t4_level", 64'(level), 64'd3);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      exp_q.delete(); expd_q.delete(); exps_q.delete();
      check_reset_state("t4_rst");
      drive_push(AW'('h7), 32'h77, 4'h1, 1'b1);
      tick();
      push = 1'b0;
      check("t4_head_addr", 64'(write_addr), 64'h7);
      check("t4_level2",    64'(level), 64'd1);
      drain();

      // 5: merge into newest entry
      drive_push(AW'('h20), 32'h11111111, 4'h1, 1'b1);
      tick();
      drive_push(AW'('h30), 32'h33333333, 4'h1, 1'b1);
      tick();
`ifdef IOB_CACHE_WTB_MERGE_EN
      drive_push(AW'('h30), 32'h22222222, 4'h2, 1'b0);
      expd_q[expd_q.size()-1] = 32'h33332233;
      exps_q[exps_q.size()-1] = 4'h3;
      tick();
      push = 1'b0;
      check("t5_level", 64'(level), 64'd2);
`else
      drive_push(AW'('h30), 32'h22222222, 4'h2, 1'b1);
      tick();
      push = 1'b0;
      check("t5_level", 64'(level), 64'd3);
`endif
      drain();

      // 6: push at full with a simultaneous pop
      for (int i = 0; i < 4; i++) begin
         drive_push(AW'('h40 + i), 32'h40404040, 4'hF, 1'b1);
         tick();
      end
      check("t6_full", 64'(full), 64'd1);
      drive_push(AW'('h50), 32'h50505050, 4'hF, 1'b0);
      write_ready = 1'b1;
      check_head();
      tick();
      push = 1'b0;
      write_ready = 1'b0;
      check("t6_refused_level", 64'(level), 64'd3);
      check("t6_refused_head",  64'(write_addr), 64'h41);
      drive_push(AW'('h60), 32'h60606060, 4'h1, 1'b1);
      tick();
      check("t6_full2", 64'(full), 64'd1);
`ifdef IOB_CACHE_WTB_MERGE_EN
      drive_push(AW'('h60), 32'hABABABAB, 4'h2, 1'b0);
      expd_q[expd_q.size()-1] = 32'h6060AB60;
      exps_q[exps_q.size()-1] = 4'h3;
`else
      drive_push(AW'('h60), 32'hABABABAB, 4'h2, 1'b0);
`endif
      write_ready = 1'b1;
      check_head();
      tick();
      push = 1'b0;
      write_ready = 1'b0;
      check("t6_level", 64'(level), 64'd3);
      check("t6_notfull", 64'(full), 64'd0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iob_cache_write_buffer.md
# iob_cache_write_buffer

Write-through buffer between the cache front-end and the back-end write channel. Queues front-end word writes (address, data, byte strobe) in a small FIFO and drains them one at a time over the back-end write handshake (`write_valid`/`write_ready`). The front-end can therefore retire writes without waiting on back-end memory latency.

## Interface
Parameters:
- `ADDR_W`, 32, front-end byte-address width
- `DATA_W`, 32, word width; NBYTES = DATA_W/8, NBYTES_W = log2(NBYTES)
- `DEPTH_W`, 2, log2 of FIFO depth (DEPTH = 2**DEPTH_W entries)

Ports:
- `clk_i`  in  1  clock; single clock domain
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on rising `clk_i`)
- `push`  in  1  front-end write request, single-cycle qualifier
- `push_addr`  in  ADDR_W-NBYTES_W  word address
- `push_wdata`  in  DATA_W  write data
- `push_wstrb`  in  NBYTES  byte enables, nonzero
- `full`  out  1  no free entry
- `empty`  out  1  no entry held
- `level`  out  DEPTH_W+1  entries held, 0..DEPTH
- `write_valid`  out  1  head entry presented to write channel
- `write_addr`  out  ADDR_W-NBYTES_W  head address
- `write_wdata`  out  DATA_W  head data
- `write_wstrb`  out  NBYTES  head strobe
- `write_ready`  in  1  write channel completed head transfer

## Operation
- Storage: DEPTH-entry circular array {addr, wdata, wstrb}; read pointer `rptr` and write pointer `wptr` are DEPTH_W bits and wrap modulo DEPTH; `level` is a separate counter.
- `empty` = (level==0), `full` = (level==DEPTH), both derived from the registered `level`.
- Push accepted iff `push` && !`full` (or merged, see Configuration): the entry is written at `wptr`, and `wptr` increments. A push while `full` that does not merge is ignored with no state change; upstream must gate on `full`.
- `write_valid` = !`empty`. `write_addr/wdata/wstrb` are driven from the entry at `rptr` and are held stable while `write_valid`=1 and `write_ready`=0.
- Pop when `write_valid` && `write_ready`: `rptr` increments. `write_ready` while empty is ignored.
- Simultaneous accepted push and pop: `level` is unchanged and both pointers advance.
- Push while `full` with `write_ready`=1 in the same cycle: the push is refused, because `full` is registered.
- Ordering is strict FIFO; no entry is reordered or dropped.

## Timing
- Reset (`reset`=0 at an edge): `level`=0, `rptr`=`wptr`=0, all array entries zeroed. Outputs: `empty`=1, `full`=0, `write_valid`=0, `write_addr`=`write_wdata`=`write_wstrb`=0. Reset mid-transfer discards all entries; any in-flight write-channel transaction is not tracked.
- Push into an empty buffer at edge N gives `write_valid`=1 from cycle N+1. Minimum fill-to-drain latency is 1 cycle.
- Pop at edge N: the next entry (if any) is presented in cycle N+1.
- Sustained throughput is 1 push and 1 pop per cycle.
- `level`, `full` and `empty` update on the edge following the accepting push or pop.

## Configuration
- `IOB_CACHE_WTB_MERGE_EN` defined: write coalescing is enabled. A push merges into the newest entry (at `wptr`-1) when all of the following hold:
  - `level`>=2, so the newest entry is not the head under handshake;
  - the newest entry is not popped in the same cycle;
  - `push_addr` equals its address.
- On a merge:
  - bytes where `push_wstrb`=1 overwrite the stored data;
  - the stored strobe becomes the OR of the stored strobe and `push_wstrb`;
  - `level` and `wptr` are unchanged.
  - A merge is accepted even while `full`.
- `IOB_CACHE_WTB_MERGE_EN` undefined: every accepted push allocates a new entry, and there is no address comparator.

## Test plan
- Reset, then push addr 0x10, wdata 0xAABBCCDD, wstrb 0xF with `write_ready`=0 -> next cycle `write_valid`=1, `write_addr`=0x10, `level`=1, held for 5 cycles; assert `write_ready` for 1 cycle -> `empty`=1 the cycle after.
- Push 4 writes (addr 1..4) with `write_ready`=0 -> `full`=1, `level`=4; 5th push addr 5 ignored; drain with `write_ready`=1 -> addrs 1,2,3,4 in order, then `empty`=1.
- Steady streaming: push every cycle and `write_ready`=1 every cycle for 20 cycles (addr 0..19) -> `level` stays 1, all 20 addrs emerge in order, pointers wrap 5 times.
- Fill 3 entries, assert `reset`=0 for one edge while `write_valid`=1 -> all outputs at reset values next cycle; a subsequent push addr 0x7 appears as head.
- Merge enabled: push addr 0x20 wdata 0x11111111 wstrb 0x1, push addr 0x30 wstrb 0x1, push addr 0x30 wdata 0x22222222 wstrb 0x2 -> `level`=2, second entry has wstrb 0x3 and byte1=0x22. Merge disabled: same stimulus gives `level`=3.
- At `full`=1, push with `write_ready`=1 in the same cycle -> push refused and `level`=3 next cycle; with merge enabled and a matching address, the push merges and `level`=3.
